// File: rtl/eka_fetch_pkg.sv
// Shared types for the Eka instruction-fetch controller.
//   fetch_state_t : fetch sequencer states
//   redir_src_t   : which unit won the redirect arbitration this cycle
//   fetch_instr_t : an instruction word paired with its word-address PC
package eka_fetch_pkg;

   localparam int EKA_ADDR_WIDTH = 32;
   localparam int EKA_PC_WIDTH   = EKA_ADDR_WIDTH - 2;
   localparam int EKA_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      BR   = 2'd1,
      TRAP = 2'd2
   } redir_src_t;

   typedef struct packed {
      logic [EKA_DATA_WIDTH-1:0] data;
      logic [EKA_PC_WIDTH-1:0]   pc;
   } fetch_instr_t;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Combinational priority select of PC redirect requests.
// A trap always beats a branch/jump; the branch is ignored when both are
// present in the same cycle.
// Ports:
//   trap_valid / trap_target : trap vector redirect request
//   br_valid / br_target     : taken branch/jump redirect request
//   redir_src                : winning source (NONE when no redirect)
//   redir_target             : winning word-address target ('0 when NONE)
module fetch_redirect_arb
   import eka_fetch_pkg::*;
#(
   parameter int TW = 30
) (
   input  logic          trap_valid,
   input  logic [TW-1:0] trap_target,
   input  logic          br_valid,
   input  logic [TW-1:0] br_target,
   output redir_src_t    redir_src,
   output logic [TW-1:0] redir_target
);

   always_comb begin
      redir_src    = NONE;
      redir_target = '0;
      if (trap_valid) begin
         redir_src    = TRAP;
         redir_target = trap_target;
      end else if (br_valid) begin
         redir_src    = BR;
         redir_target = br_target;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Eka instruction-fetch sequencer. Owns the word-addressed PC, keeps at most
// one instruction-memory request outstanding, applies trap/branch redirects,
// squashes stale responses and hands instructions to decode through a
// one-entry output buffer backed by a one-entry skid register.
//
// Optional build macro: FETCH_CTRL_PERF_EN adds perf_fetched / perf_squashed
// saturating response counters.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   trap_valid/trap_target         : trap redirect (highest priority)
//   br_valid/br_target             : branch/jump redirect
//   imem_req_valid/ready/addr      : fetch request handshake (word address)
//   imem_rsp_valid/data            : fetch response, always accepted
//   instr_valid/ready/data/pc      : instruction to decode, valid/ready
//   perf_fetched/perf_squashed     : (FETCH_CTRL_PERF_EN only) counters
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request presented at PC, held stable until accepted
// WAIT  | request accepted, waiting for the response
// HOLD  | response parked in skid while decode is stalled, no request
module fetch_ctrl
   import eka_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-3:0] RESET_ADDR = '0,
   parameter int                    DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trap_valid,
   input  logic [ADDR_WIDTH-3:0] trap_target,
   input  logic                  br_valid,
   input  logic [ADDR_WIDTH-3:0] br_target,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-3:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
`ifdef FETCH_CTRL_PERF_EN
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_squashed,
`endif
   output logic [ADDR_WIDTH-3:0] instr_pc
);

   localparam int PW = ADDR_WIDTH - 2;

   fetch_state_t    state_q, state_d;
   redir_src_t      redir_src;
   logic            redir_valid;
   logic [PW-1:0]   redir_target;

   logic [PW-1:0]   pc_q;
   logic [PW-1:0]   inflight_pc_q;
   // pend_q marks a recorded redirect that has not been applied yet; while it
   // is set the request in flight is stale and its response is squashed.
   logic            pend_q;
   logic [PW-1:0]   pend_target_q;

   logic            out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [PW-1:0]   out_pc_q;
   logic            skid_valid_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
   logic [PW-1:0]   skid_pc_q;

   logic            rsp_take, rsp_drop, rsp_keep;
   logic            buf_free, buf_drain;

   fetch_redirect_arb #(.TW(PW)) u_arb (
      .trap_valid   (trap_valid),
      .trap_target  (trap_target),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .redir_src    (redir_src),
      .redir_target (redir_target)
   );

   assign redir_valid = (redir_src != NONE);

   // Responses are only meaningful in WAIT; anything else is a leftover from
   // before a reset and is ignored. A redirect in the response cycle wins.
   assign rsp_take  = (state_q == WAIT) && imem_rsp_valid;
   assign rsp_drop  = rsp_take && (pend_q || redir_valid);
   assign rsp_keep  = rsp_take && !rsp_drop;
   assign buf_drain = out_valid_q && instr_ready;
   assign buf_free  = !out_valid_q || instr_ready;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (imem_req_ready) state_d = WAIT;
         WAIT: if (rsp_take) state_d = (rsp_drop || buf_free) ? REQ : HOLD;
         HOLD: if (redir_valid || instr_ready) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = pc_q;
      if (state_q == REQ) imem_req_valid = 1'b1;
   end

   assign instr_valid = out_valid_q;
   assign instr_data  = out_data_q;
   assign instr_pc    = out_pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_ADDR;
         inflight_pc_q <= '0;
         pend_q        <= 1'b0;
         pend_target_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_pc_q      <= '0;
         skid_valid_q  <= 1'b0;
         skid_data_q   <= '0;
         skid_pc_q     <= '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (redir_valid) pc_q <= redir_target;
            end
            REQ: begin
               // The address must not move under an unaccepted request, so a
               // redirect here is only recorded.
               if (imem_req_ready) inflight_pc_q <= pc_q;
               if (redir_valid) begin
                  pend_q        <= 1'b1;
                  pend_target_q <= redir_target;
               end
            end
            WAIT: begin
               if (rsp_drop) begin
                  pc_q   <= redir_valid ? redir_target : pend_target_q;
                  pend_q <= 1'b0;
               end else if (rsp_keep) begin
                  pc_q <= pc_q + PW'(1);
               end else if (redir_valid) begin
                  pend_q        <= 1'b1;
                  pend_target_q <= redir_target;
               end
            end
            default: ;
         endcase

         if (redir_valid) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
         end else if (rsp_keep && buf_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= imem_rsp_data;
            out_pc_q    <= inflight_pc_q;
         end else if (rsp_keep) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= imem_rsp_data;
            skid_pc_q    <= inflight_pc_q;
         end else if (buf_drain) begin
            if (skid_valid_q) begin
               out_data_q   <= skid_data_q;
               out_pc_q     <= skid_pc_q;
               skid_valid_q <= 1'b0;
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched  <= '0;
         perf_squashed <= '0;
      end else begin
         if (rsp_keep && (perf_fetched != '1))
            perf_fetched <= perf_fetched + 32'd1;
         if (imem_rsp_valid && !rsp_keep && (perf_squashed != '1))
            perf_squashed <= perf_squashed + 32'd1;
      end
   end
`endif

endmodule
